bht_predictor: RTL and testbench
================================

# bht_predictor

Direct-mapped branch history table of 2-bit saturating counters. Sits beside the fetch stage and downstream of the execute-stage branch comparator. Fetch gets a same-cycle taken/not-taken prediction for the current PC. The comparator's resolved `br_taken` trains the table, and the block flags a mispredict so the pipeline can flush and redirect. A multi-cycle clear sequencer reinitialises the table on request.

## Interface
- `IDX_W`, 6: index width; table holds 2^IDX_W entries.
- `XLEN`, 32: PC width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lookup_valid`  in  1  fetch PC valid.
- `lookup_pc`  in  XLEN  fetch PC.
- `pred_taken`  out  1  prediction for `lookup_pc`.
- `update_valid`  in  1  resolved conditional branch in EX; this is the comparator's `branch` qualifier.
- `update_pc`  in  XLEN  PC of the resolved branch.
- `br_taken`  in  1  resolved outcome from the branch comparator.
- `pred_taken_ex`  in  1  prediction originally made for this branch, carried down the pipe.
- `mispredict`  out  1  `update_valid & (br_taken != pred_taken_ex)`.
- `clear_req`  in  1  request a full table clear.
- `busy`  out  1  clear in progress.
- `branch_cnt`  out  32  resolved-branch count (see Configuration).
- `mispred_cnt`  out  32  mispredict count (see Configuration).

## Operation
- Index is `pc[IDX_W+1:2]`. There are no tags, so aliasing PCs share an entry.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
- `pred_taken = lookup_valid & ~busy & ctr[idx][1]`. The read is combinational from flops.
- Update is applied when `update_valid & ~busy`:
  - taken: counter increments, saturating at ST.
  - not taken: counter decrements, saturating at SNT.
- `mispredict` is combinational. It is not gated by `busy`, because a flush is still required.
- FSM states: IDLE and CLEAR.
  - IDLE: `clear_req` high at an edge moves to CLEAR and loads `clr_idx=0`.
  - CLEAR: each cycle writes WNT to entry `clr_idx`, then increments it. After writing entry 2^IDX_W-1, returns to IDLE.
  - `busy = (state==CLEAR)`.
  - `clear_req` while in CLEAR is ignored.
  - Updates during CLEAR are dropped.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value. There is no bypass.

## Timing
- Reset, asynchronous:
  - every entry WNT; state IDLE; `clr_idx=0`; counters 0.
  - Consequently `pred_taken=0` and `busy=0`. `mispredict` follows its inputs.
- Prediction latency 0 cycles. Update is visible to a lookup on the cycle after the update edge.
- Clear timing:
  - `busy` rises the cycle after the `clear_req` edge.
  - `busy` stays high for exactly 2^IDX_W cycles (64 at default).
  - Predictions are 0 throughout.
- Reset asserted mid-clear aborts to IDLE, with the table at WNT via the reset path.

## Configuration
- `BHT_STATS_EN` defined:
  - `branch_cnt` increments on every `update_valid` edge, including during CLEAR.
  - `mispred_cnt` increments on every `mispredict` edge.
  - Both are 32-bit and wrap modulo 2^32.
- `BHT_STATS_EN` undefined:
  - both counter outputs are tied to 0 and no counter flops exist.
  - Ports remain, so the port list is identical.

## Structure
- Package `bht_pkg` holds:
  - `ctr_t` enum (SNT/WNT/WT/ST) and the `CTR_INIT=WNT` constant.
  - `bht_state_t` (IDLE/CLEAR).
- Sub-module `bht_ctr_next`: a combinational block taking current `ctr_t` and taken, returning the saturated next `ctr_t`. It is used by the update path.
- Table storage is a flop array in `bht_predictor`. It is not SRAM, because it needs asynchronous reset and same-cycle read.

## Test plan
- Reset:
  - Stimulus: assert reset, then look up pc 0x0, 0x100 and 0xFC.
  - Expected: `pred_taken=0` for all three; `busy=0`; counters 0.
- Training:
  - Stimulus: update pc 0x100 taken, 1 cycle apart.
  - Expected: after the first update, lookup 0x100 gives 1 (WNT->WT); after the second the counter is ST.
  - Stimulus: then two not-taken updates.
  - Expected: ST->WT->WNT, and lookup gives 0.
- Aliasing and same-cycle read:
  - Stimulus: train 0x100 taken (0x100 and 0x200 map to index 0 at IDX_W=6).
  - Expected: lookup 0x200 predicts 1.
  - Stimulus: lookup 0x100 in the same cycle as its first taken update from WNT.
  - Expected: returns 0.
- Mispredict:
  - Stimulus: `update_valid=1`, `br_taken=1`, `pred_taken_ex=0`.
  - Expected: `mispredict=1` that cycle; with `BHT_STATS_EN`, `mispred_cnt` goes 0->1 and `branch_cnt` goes 0->1 at the edge.
  - Stimulus: matching prediction.
  - Expected: `mispredict=0`.
- Clear:
  - Stimulus: train index 5 to ST, then pulse `clear_req`.
  - Expected: `busy` high for 64 cycles.
  - Stimulus: a taken update to 0x14 mid-clear.
  - Expected: dropped.
  - Expected afterwards: lookup 0x14 gives 0 and the entry is WNT.
- Reset mid-clear:
  - Stimulus: assert reset at clear cycle 10.
  - Expected: `busy=0` immediately and all entries WNT.

Source files
------------

// File: rtl/bht_pkg.sv
// Shared types for the branch history table: 2-bit counter encoding and
// the clear-sequencer state.
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_INIT = WNT;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bht_state_t;

endpackage

// File: rtl/bht_ctr_next.sv
// Saturating next-state function for one 2-bit branch counter.
module bht_ctr_next
    import bht_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_nxt
);

    always_comb begin
        // NOTE: default assignment first so every path drives ctr_nxt and no latch is inferred.
        ctr_nxt = ctr;
        case (ctr)
            SNT: ctr_nxt = taken ? WNT : SNT;
            WNT: ctr_nxt = taken ? WT  : SNT;
            WT:  ctr_nxt = taken ? ST  : WNT;
            ST:  ctr_nxt = taken ? ST  : WT;
            default: ctr_nxt = ctr;
        endcase
    end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped 2-bit branch history table with a multi-cycle clear sequencer.
// Optional resolved-branch / mispredict statistics enabled by BHT_STATS_EN.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            br_taken,
    input  logic            pred_taken_ex,
    output logic            mispredict,
    input  logic            clear_req,
    output logic            busy,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    ctr_t             table_q [ENTRIES];
    bht_state_t       state_q;
    logic [IDX_W-1:0] clr_idx_q;

    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       lkp_bits;
    ctr_t             upd_ctr_nxt;
    logic             unused_pc_bits;

    assign lkp_idx  = lookup_pc[IDX_W+1:2];
    assign upd_idx  = update_pc[IDX_W+1:2];
    assign lkp_bits = table_q[lkp_idx];

    // Untagged table: the PC bits outside the index field are intentionally ignored.
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                              update_pc[XLEN-1:IDX_W+2], update_pc[1:0]};

    assign busy       = (state_q == CLEAR);
    assign pred_taken = lookup_valid & ~busy & lkp_bits[1];
    assign mispredict = update_valid & (br_taken ^ pred_taken_ex);

    bht_ctr_next u_ctr_next (
        .ctr     (table_q[upd_idx]),
        .taken   (br_taken),
        .ctr_nxt (upd_ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the flop-array table is reset entry by entry so predictions are defined straight out of reset.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_INIT;
            end
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (update_valid) begin
                        table_q[upd_idx] <= upd_ctr_nxt;
                    end
                    if (clear_req) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                    end
                end
                CLEAR: begin
                    table_q[clr_idx_q] <= CTR_INIT;
                    clr_idx_q          <= clr_idx_q + 1'b1;
                    if (clr_idx_q == {IDX_W{1'b1}}) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BHT_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Counting continues during a clear; the pipeline still resolves and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (update_valid) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed vector table, clear and
// reset-mid-clear sequences, then randomized traffic against a reference model.
module tb_bht_predictor;

    localparam int IDX_W   = 6;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
`ifdef BHT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            lookup_valid;
    logic [XLEN-1:0] lookup_pc;
    logic            pred_taken;
    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            br_taken;
    logic            pred_taken_ex;
    logic            mispredict;
    logic            clear_req;
    logic            busy;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: counter values 0..3 per entry, remaining clear cycles, stats.
    int          m_tbl [ENTRIES];
    int          m_busy_left;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        bt;
        logic        pex;
        logic        exp_pred;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [12];

    bht_predictor #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_valid  (lookup_valid),
        .lookup_pc     (lookup_pc),
        .pred_taken    (pred_taken),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .br_taken      (br_taken),
        .pred_taken_ex (pred_taken_ex),
        .mispredict    (mispredict),
        .clear_req     (clear_req),
        .busy          (busy),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic m_pred();
        return lookup_valid && (m_busy_left == 0) && (m_tbl[m_idx(lookup_pc)] >= 2);
    endfunction

    function automatic logic m_mis();
        return update_valid && (br_taken != pred_taken_ex);
    endfunction

    task automatic m_reset();
        foreach (m_tbl[i]) m_tbl[i] = 1;
        m_busy_left = 0;
        m_br        = '0;
        m_mp        = '0;
    endtask

    task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic bt, input logic pex,
                         input logic clr);
        lookup_valid  = lv;
        lookup_pc     = lpc;
        update_valid  = uv;
        update_pc     = upc;
        br_taken      = bt;
        pred_taken_ex = pex;
        clear_req     = clr;
    endtask

    // Advance the model by one edge using the currently driven inputs, then clock the DUT.
    task automatic tick();
        int i;
        if (STATS) begin
            if (update_valid) m_br = m_br + 32'd1;
            if (m_mis())      m_mp = m_mp + 32'd1;
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            if (update_valid) begin
                i = m_idx(update_pc);
                if (br_taken) m_tbl[i] = (m_tbl[i] < 3) ? m_tbl[i] + 1 : 3;
                else          m_tbl[i] = (m_tbl[i] > 0) ? m_tbl[i] - 1 : 0;
            end
            if (clear_req) begin
                foreach (m_tbl[k]) m_tbl[k] = 1;
                m_busy_left = ENTRIES;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pred"}, 32'(pred_taken), 32'(m_pred()));
        check({tag, "_mis"},  32'(mispredict), 32'(m_mis()));
        check({tag, "_busy"}, 32'(busy),       32'(m_busy_left > 0));
        check({tag, "_bcnt"}, branch_cnt,      m_br);
        check({tag, "_mcnt"}, mispred_cnt,     m_mp);
    endtask

    initial begin
        int busy_cycles;

        // Directed vectors, applied in order from a freshly reset (all-WNT) table.
        vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_00FC, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0014, 1'b0, 32'h0000_0014, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0014, 1'b0, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0};

        // Reset
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        m_reset();
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcnt", branch_cnt, 32'd0);
        check("rst_mcnt", mispred_cnt, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_mis_follows", 32'(mispredict), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].lv, vecs[v].lpc, vecs[v].uv, vecs[v].upc, vecs[v].bt, vecs[v].pex, 1'b0);
            #1;
            check($sformatf("vec%0d_pred", v), 32'(pred_taken), 32'(vecs[v].exp_pred));
            check($sformatf("vec%0d_mis", v),  32'(mispredict), 32'(vecs[v].exp_mis));
            tick();
            if (v == 3) begin
                check("first_bcnt", branch_cnt,  STATS ? 32'd1 : 32'd0);
                check("first_mcnt", mispred_cnt, STATS ? 32'd1 : 32'd0);
            end
        end
        check("vec_bcnt", branch_cnt,  STATS ? 32'd6 : 32'd0);
        check("vec_mcnt", mispred_cnt, STATS ? 32'd4 : 32'd0);

        // Clear: index 5 is ST here; a taken update to it mid-clear must be dropped.
        drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("preclr_pred", 32'(pred_taken), 32'd1);
        tick();
        check("clr_busy_rise", 32'(busy), 32'd1);
        busy_cycles = 0;
        for (int c = 0; c < 200 && busy; c++) begin
            busy_cycles++;
            drive(1'b1, 32'h14, (c == 3), 32'h14, 1'b1, 1'b1, (c == 7));
            #1;
            check("clr_pred", 32'(pred_taken), 32'd0);
            tick();
        end
        check("clr_busy_len", 32'(busy_cycles), 32'd64);
        drive(1'b1, 32'h14, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
        #1;
        check("postclr_pred", 32'(pred_taken), 32'd0);
        tick();
        drive(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("postclr_wnt", 32'(pred_taken), 32'd1);
        check("postclr_bcnt", branch_cnt, m_br);
        check("postclr_mcnt", mispred_cnt, m_mp);

        // Reset mid-clear: idx 40 -> SNT, idx 41 -> ST, then abort a clear at cycle 10.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, 32'h0, 1'b1, 32'hA4, 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hA4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcnt", branch_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle", 32'(busy), 32'd0);
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 32'(i * 4), 1'b1, 1'b1, 1'b0);
            #1;
            check($sformatf("wnt_lo%0d", i), 32'(pred_taken), 32'd0);
            tick();
        end
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("wnt_hi%0d", i), 32'(pred_taken), 32'd1);
            tick();
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_FF03),
                  1'($urandom_range(0, 2) != 0),
                  (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'hFFFF_FF03),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 149) == 0));
            #1;
            check_model("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
